store_buffer: RTL and testbench

- Write-buffer stage sitting directly upstream of the data memory, between the MEM pipeline stage and the memory's single address/data port.
- Stores from the pipeline are queued in a small FIFO and drained to memory one per cycle, whenever the port is not needed by a load.
- Loads have priority on the memory port. Each load is served with store-to-load forwarding from the youngest matching buffered entry.
- A stall is raised when a store arrives while the buffer is full.

---
 rtl/store_buffer.sv | 132 +++++++++++++
 tb/tb_store_buffer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - store FIFO in front of data memory with load forwarding (optional STORE_BUF_COALESCE_EN)
module store_buffer #(
    parameter int ADDRESS_LINE = 8,
    parameter int DEPTH        = 4,
    parameter int PTR_W        = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    st_valid,
    input  logic [ADDRESS_LINE-1:0] st_addr,
    input  logic [7:0]              st_data,
    input  logic                    ld_valid,
    input  logic [ADDRESS_LINE-1:0] ld_addr,
    output logic [7:0]              ld_data,
    output logic                    ld_fwd,
    output logic                    stall,
    output logic                    empty,
    output logic [ADDRESS_LINE-1:0] mem_address,
    output logic [7:0]              mem_write_data,
    output logic                    mem_write,
    output logic                    mem_read,
    input  logic [7:0]              mem_read_data
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [ADDRESS_LINE-1:0] addr_q [DEPTH];
    logic [7:0]              data_q [DEPTH];
    logic [PTR_W-1:0]        head_q, head_d;
    logic [PTR_W-1:0]        tail_q, tail_d;
    logic [PTR_W:0]          count_q, count_d;

    logic full;
    logic drain;
    logic enq;
    logic coal;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign drain = reset && !empty && !ld_valid;

`ifdef STORE_BUF_COALESCE_EN
    logic [PTR_W-1:0] young_idx;
    assign young_idx = tail_q - PTR_W'(1);
    // A lone entry leaving this cycle cannot absorb the store; it must allocate.
    assign coal = reset && st_valid && !empty && (addr_q[young_idx] == st_addr)
                  && !((count_q == (PTR_W+1)'(1)) && drain);
`else
    assign coal = 1'b0;
`endif

    assign enq   = reset && st_valid && !full && !coal;
    assign stall = reset && st_valid && full && !coal;

    logic             fwd_hit;
    logic [7:0]       fwd_data;
    logic [PTR_W-1:0] scan_idx;

    // Walk oldest to youngest so the last hit wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PTR_W'(i);
            if (((PTR_W+1)'(i) < count_q) && (addr_q[scan_idx] == ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[scan_idx];
            end
        end
    end

    always_comb begin
        ld_fwd         = 1'b0;
        ld_data        = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        if (reset) begin
            if (ld_valid) begin
                mem_read    = 1'b1;
                mem_address = ld_addr;
                ld_fwd      = fwd_hit;
                ld_data     = fwd_hit ? fwd_data : mem_read_data;
            end else if (drain) begin
                mem_write      = 1'b1;
                mem_address    = addr_q[head_q];
                mem_write_data = data_q[head_q];
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (drain) head_d = head_q + PTR_W'(1);
        if (enq)   tail_d = tail_q + PTR_W'(1);
        case ({enq, drain})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (enq) begin
                addr_q[tail_q] <= st_addr;
                data_q[tail_q] <= st_data;
            end
`ifdef STORE_BUF_COALESCE_EN
            else if (coal) begin
                data_q[young_idx] <= st_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed table, corner sequences and random run against a queue model
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       st_valid, ld_valid;
    logic [7:0] st_addr, st_data, ld_addr;
    logic [7:0] ld_data, mem_address, mem_write_data, mem_read_data;
    logic       ld_fwd, stall, empty, mem_write, mem_read;

    always #5 clock = ~clock;

    store_buffer #(.ADDRESS_LINE(8), .DEPTH(DEPTH), .PTR_W(2)) dut (
        .clock(clock), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .ld_valid(ld_valid), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_fwd(ld_fwd), .stall(stall), .empty(empty),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
    );

    logic [7:0] mem     [256];
    logic [7:0] exp_mem [256];
    logic [7:0] init_mem[256];
    assign mem_read_data = mem[mem_address];
    always @(posedge clock) if (mem_write) mem[mem_address] <= mem_write_data;

    typedef struct { logic [7:0] a; logic [7:0] d; } ent_t;
    ent_t model_q[$];

    typedef struct {
        logic r, s; logic [7:0] sa, sd; logic l; logic [7:0] la;
        logic x_stall, x_mw; logic [7:0] x_ma, x_wd; logic x_fwd; logic [7:0] x_ld;
    } vec_t;
    vec_t vecs[20];
    vec_t cur;
    bit   use_vec;

    int errors = 0;
    int checks = 0;
    int wr40   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, s, input logic [7:0] sa, sd, input logic l,
                                input logic [7:0] la, input logic xs, xw, input logic [7:0] xa, xd,
                                input logic xf, input logic [7:0] xl);
        vec_t v;
        v.r = r; v.s = s; v.sa = sa; v.sd = sd; v.l = l; v.la = la;
        v.x_stall = xs; v.x_mw = xw; v.x_ma = xa; v.x_wd = xd; v.x_fwd = xf; v.x_ld = xl;
        return v;
    endfunction

    task automatic step(input logic r, s, input logic [7:0] sa, sd, input logic l, input logic [7:0] la);
        int sz;
        bit dr, co, hit;
        logic [7:0] fd;
        reset = r; st_valid = s; st_addr = sa; st_data = sd; ld_valid = l; ld_addr = la;
        @(negedge clock);
        sz  = model_q.size();
        dr  = r && sz > 0 && !l;
        co  = 1'b0;
`ifdef STORE_BUF_COALESCE_EN
        co  = r && s && sz > 0 && model_q[sz-1].a == sa && !(sz == 1 && dr);
`endif
        hit = 1'b0; fd = exp_mem[la];
        for (int i = sz - 1; i >= 0; i--)
            if (model_q[i].a == la) begin hit = 1'b1; fd = model_q[i].d; break; end
        chk("empty", empty, sz == 0);
        chk("stall", stall, r && s && sz == DEPTH && !co);
        chk("mem_write", mem_write, dr);
        chk("mem_read", mem_read, r && l);
        if (!r) begin
            chk("rst_ld_fwd", ld_fwd, 0);
            chk("rst_ld_data", ld_data, 0);
        end else begin
            chk("mem_address", mem_address, l ? la : (dr ? model_q[0].a : 8'h00));
            if (dr) chk("mem_write_data", mem_write_data, model_q[0].d);
            if (!l && sz == 0) chk("idle_wdata", mem_write_data, 0);
            if (l) begin
                chk("ld_fwd", ld_fwd, hit);
                chk("ld_data", ld_data, fd);
            end
        end
        if (use_vec) begin
            chk("tbl_stall", stall, cur.x_stall);
            chk("tbl_mem_write", mem_write, cur.x_mw);
            if (cur.r) chk("tbl_mem_address", mem_address, cur.x_ma);
            if (cur.x_mw) chk("tbl_wdata", mem_write_data, cur.x_wd);
            if (cur.l) begin
                chk("tbl_ld_fwd", ld_fwd, cur.x_fwd);
                chk("tbl_ld_data", ld_data, cur.x_ld);
            end
        end
        if (mem_write && mem_address == 8'h40) wr40++;
        @(posedge clock);
        if (!r) model_q.delete();
        else begin
            if (dr) begin exp_mem[model_q[0].a] = model_q[0].d; void'(model_q.pop_front()); end
            if (co) model_q[model_q.size()-1].d = sd;
            else if (s && sz < DEPTH) model_q.push_back('{a: sa, d: sd});
        end
        #1;
    endtask

    task automatic idle(); step(1, 0, 0, 0, 0, 0); endtask

    initial begin
        for (int i = 0; i < 256; i++) init_mem[i] = 8'(i) ^ 8'h3C;
        init_mem[8'h21] = 8'h5C;
        for (int i = 0; i < 256; i++) begin mem[i] = init_mem[i]; exp_mem[i] = init_mem[i]; end
        use_vec = 0;

        vecs[0]  = mk(1,1,8'h10,8'hAA,0,8'h00, 0,0,8'h00,8'h00,0,8'h00);
        vecs[1]  = mk(1,1,8'h11,8'hBB,0,8'h00, 0,1,8'h10,8'hAA,0,8'h00);
        vecs[2]  = mk(1,0,8'h00,8'h00,0,8'h00, 0,1,8'h11,8'hBB,0,8'h00);
        vecs[3]  = mk(1,0,8'h00,8'h00,0,8'h00, 0,0,8'h00,8'h00,0,8'h00);
        vecs[4]  = mk(1,1,8'h20,8'h01,1,8'h20, 0,0,8'h20,8'h00,0,8'h1C);
        vecs[5]  = mk(1,1,8'h20,8'h02,1,8'h20, 0,0,8'h20,8'h00,1,8'h01);
        vecs[6]  = mk(1,0,8'h00,8'h00,1,8'h20, 0,0,8'h20,8'h00,1,8'h02);
        vecs[7]  = mk(1,0,8'h00,8'h00,1,8'h21, 0,0,8'h21,8'h00,0,8'h5C);
        vecs[8]  = mk(0,1,8'h10,8'h77,0,8'h00, 0,0,8'h00,8'h00,0,8'h00);
        for (int k = 0; k < 4; k++)
            vecs[9+k] = mk(1,1,8'h30+8'(k),8'hD0+8'(k),1,8'h50, 0,0,8'h50,8'h00,0,8'h6C);
        vecs[13] = mk(1,1,8'h34,8'hD4,1,8'h50, 1,0,8'h50,8'h00,0,8'h6C);
        vecs[14] = mk(1,1,8'h34,8'hD4,0,8'h00, 1,1,8'h30,8'hD0,0,8'h00);
        vecs[15] = mk(1,1,8'h34,8'hD4,0,8'h00, 0,1,8'h31,8'hD1,0,8'h00);
        for (int k = 0; k < 3; k++)
            vecs[16+k] = mk(1,0,8'h00,8'h00,0,8'h00, 0,1,8'h32+8'(k),8'hD2+8'(k),0,8'h00);
        vecs[19] = mk(1,0,8'h00,8'h00,0,8'h00, 0,0,8'h00,8'h00,0,8'h00);

        // reset held with a store presented: nothing may reach memory
        step(0, 1, 8'h10, 8'h77, 0, 0);
        step(0, 1, 8'h10, 8'h77, 0, 0);
        idle();
        idle();
        chk("reset_mem10", mem[8'h10], init_mem[8'h10]);

        use_vec = 1;
        for (int i = 0; i < 20; i++) begin
            cur = vecs[i];
            step(cur.r, cur.s, cur.sa, cur.sd, cur.l, cur.la);
        end
        use_vec = 0;
        for (int k = 0; k < 5; k++) chk("fifo_mem", mem[8'h30+8'(k)], 8'hD0+8'(k));

        // wrap pointers, then reset with two entries pending
        for (int i = 0; i < 6; i++) step(1, 1, 8'h60 + 8'(i), 8'hE0 + 8'(i), (i % 2) == 0, 8'h00);
        idle();
        chk("pending_before_reset", model_q.size(), 2);
        step(0, 0, 0, 0, 0, 0);
        idle();
        idle();
        chk("empty_after_reset", empty, 1);
        chk("discard_64", mem[8'h64], init_mem[8'h64]);
        chk("discard_65", mem[8'h65], init_mem[8'h65]);

        // same-address back-to-back stores while loads block the drain
        wr40 = 0;
        step(1, 1, 8'h40, 8'h11, 1, 8'h40);
        step(1, 1, 8'h40, 8'h22, 1, 8'h40);
        idle(); idle(); idle();
`ifdef STORE_BUF_COALESCE_EN
        chk("coalesce_writes", wr40, 1);
`else
        chk("coalesce_writes", wr40, 2);
`endif
        chk("mem40", mem[8'h40], 8'h22);

        for (int n = 0; n < 400; n++) begin
            logic rr, ss, ll;
            rr = ($urandom_range(0, 39) != 0);
            ss = ($urandom_range(0, 9) < 6);
            ll = ($urandom_range(0, 9) < 4);
            step(rr, ss, 8'h70 + 8'($urandom_range(0, 3)), 8'($urandom), ll,
                 8'h70 + 8'($urandom_range(0, 4)));
        end
        for (int k = 0; k < 8; k++) idle();
        chk("final_empty", empty, 1);
        for (int i = 0; i < 256; i++) chk("final_mem", mem[i], exp_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
